// File: rtl/bank_timing_fsm_pkg.sv
// Shared bank timing types: state codes decoded by the row-sync stage, bank command encodings
// and a small elaboration helper for sizing timing counters.
package mem_timing_pkg;

    localparam logic [4:0] ST_IDLE_C        = 5'b00000;
    localparam logic [4:0] ST_ACTIVATING_C  = 5'b00001;
    localparam logic [4:0] ST_BANKACTIVE_C  = 5'b00010;
    localparam logic [4:0] ST_PRECHARGING_C = 5'b01010;
    localparam logic [4:0] ST_READING_C     = 5'b01011;
    localparam logic [4:0] ST_READBURST_C   = 5'b01100;
    localparam logic [4:0] ST_WRITING_C     = 5'b10010;
    localparam logic [4:0] ST_WRITEBURST_C  = 5'b10011;
    localparam logic [4:0] ST_REFRESHING_C  = 5'b11000;

    typedef enum logic [4:0] {
        BS_IDLE        = ST_IDLE_C,
        BS_ACTIVATING  = ST_ACTIVATING_C,
        BS_BANKACTIVE  = ST_BANKACTIVE_C,
        BS_PRECHARGING = ST_PRECHARGING_C,
        BS_READING     = ST_READING_C,
        BS_READBURST   = ST_READBURST_C,
        BS_WRITING     = ST_WRITING_C,
        BS_WRITEBURST  = ST_WRITEBURST_C,
        BS_REFRESHING  = ST_REFRESHING_C
    } bank_state_t;

    // 110 and 111 are deliberately absent: they decode as illegal.
    typedef enum logic [2:0] {
        CMD_NOP = 3'b000,
        CMD_ACT = 3'b001,
        CMD_RD  = 3'b010,
        CMD_WR  = 3'b011,
        CMD_PRE = 3'b100,
        CMD_REF = 3'b101
    } bank_cmd_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bank_timing_fsm_if.sv
// Command/status bundle between the command decoder, one bank timing FSM and the row-sync stage.
// master = command source side, slave = bank FSM side.
interface bank_timing_fsm_if #(
    parameter int ADDRWIDTH = 17
);
    logic [2:0]           cmd;
    logic                 cmd_valid;
    logic [ADDRWIDTH-1:0] row;
    logic                 stall;
    logic                 cmd_ready;
    logic                 cmd_err;
    logic [4:0]           BankFSM;
    logic [ADDRWIDTH-1:0] RowId;

    modport master (
        output cmd, cmd_valid, row, stall,
        input  cmd_ready, cmd_err, BankFSM, RowId
    );

    modport slave (
        input  cmd, cmd_valid, row, stall,
        output cmd_ready, cmd_err, BankFSM, RowId
    );
endinterface

// File: rtl/bank_timing_fsm_timing_counter.sv
// Loadable down-counter with hold and zero flag; load wins over hold, saturates at zero.
// Value visible one cycle after load; hold freezes the count indefinitely.
module timing_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         hold_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bank_timing_fsm.sv
// Per-bank DRAM timing FSM: accepted command changes BankFSM next edge; timed states last their duration.
// Stall freezes state and counter and blocks command acceptance; cmd_err is a registered 1-cycle pulse.
module bank_timing_fsm #(
    parameter int ADDRWIDTH = 17,
    parameter int TRCD      = 14,
    parameter int TRP       = 14,
    parameter int TCL       = 14,
    parameter int TCWL      = 12,
    parameter int BL        = 8,
    parameter int TRFC      = 256
) (
    input logic             clk,
    input logic             reset_n,
    bank_timing_fsm_if.slave bus
);
    import mem_timing_pkg::*;

    localparam int BURST   = BL / 2;
    localparam int MAX_DUR = max_int(max_int(max_int(TRCD, TRP), max_int(TCL, TCWL)),
                                     max_int(BURST, TRFC));
    localparam int CNT_W   = $clog2(MAX_DUR) + 1;

    // Counter is loaded with duration-1 so that the zero flag marks the final cycle of a state.
    localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] LD_CL    = CNT_W'(TCL - 1);
    localparam logic [CNT_W-1:0] LD_CWL   = CNT_W'(TCWL - 1);
    localparam logic [CNT_W-1:0] LD_BURST = CNT_W'(BURST - 1);
    localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(TRFC - 1);

    bank_state_t          state_q, state_d;
    logic [ADDRWIDTH-1:0] row_q, row_d;
    logic                 err_q, err_d;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_val;
    logic                 cnt_zero;
    logic                 cmd_rdy;
    logic                 accept;
    logic                 timed_done;
    bank_cmd_t            cmd_e;

    assign cmd_e      = bank_cmd_t'(bus.cmd);
    assign cmd_rdy    = ((state_q == BS_IDLE) || (state_q == BS_BANKACTIVE)) && !bus.stall;
    assign accept     = bus.cmd_valid && cmd_rdy;
    assign timed_done = cnt_zero && !bus.stall;

    timing_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .hold_i     (bus.stall),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            BS_IDLE: begin
                if (accept) begin
                    case (cmd_e)
                        CMD_ACT: begin
                            state_d  = BS_ACTIVATING;
                            row_d    = bus.row;
                            cnt_load = 1'b1;
                            cnt_val  = LD_RCD;
                        end
                        CMD_REF: begin
                            state_d  = BS_REFRESHING;
                            cnt_load = 1'b1;
                            cnt_val  = LD_RFC;
                        end
                        CMD_PRE, CMD_NOP: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            BS_BANKACTIVE: begin
                if (accept) begin
                    case (cmd_e)
                        CMD_RD: begin
                            state_d  = BS_READING;
                            cnt_load = 1'b1;
                            cnt_val  = LD_CL;
                        end
                        CMD_WR: begin
                            state_d  = BS_WRITING;
                            cnt_load = 1'b1;
                            cnt_val  = LD_CWL;
                        end
                        CMD_PRE: begin
                            state_d  = BS_PRECHARGING;
                            cnt_load = 1'b1;
                            cnt_val  = LD_RP;
                        end
                        CMD_NOP: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            BS_ACTIVATING: begin
                if (timed_done) state_d = BS_BANKACTIVE;
            end
            BS_READING: begin
                if (timed_done) begin
                    state_d  = BS_READBURST;
                    cnt_load = 1'b1;
                    cnt_val  = LD_BURST;
                end
            end
            BS_WRITING: begin
                if (timed_done) begin
                    state_d  = BS_WRITEBURST;
                    cnt_load = 1'b1;
                    cnt_val  = LD_BURST;
                end
            end
            BS_READBURST, BS_WRITEBURST: begin
                if (timed_done) state_d = BS_BANKACTIVE;
            end
            BS_PRECHARGING, BS_REFRESHING: begin
                if (timed_done) state_d = BS_IDLE;
            end
            default: state_d = BS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BS_IDLE;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready = cmd_rdy;
    assign bus.cmd_err   = err_q;
    assign bus.BankFSM   = state_q;
    assign bus.RowId     = row_q;

endmodule

// File: tb/tb_bank_timing_fsm.sv
// Scoreboard bench for bank_timing_fsm: a cycle model pushes expected state/row/err per cycle,
// a negedge monitor pops and compares; run lengths per state are measured for duration checks.
module tb_bank_timing_fsm;

    localparam int AW = 17;

    localparam logic [4:0] E_IDLE = 5'b00000;
    localparam logic [4:0] E_ACTG = 5'b00001;
    localparam logic [4:0] E_BA   = 5'b00010;
    localparam logic [4:0] E_PRE  = 5'b01010;
    localparam logic [4:0] E_RD   = 5'b01011;
    localparam logic [4:0] E_RB   = 5'b01100;
    localparam logic [4:0] E_WR   = 5'b10010;
    localparam logic [4:0] E_WB   = 5'b10011;
    localparam logic [4:0] E_REF  = 5'b11000;

    localparam logic [2:0] C_NOP = 3'b000;
    localparam logic [2:0] C_ACT = 3'b001;
    localparam logic [2:0] C_RD  = 3'b010;
    localparam logic [2:0] C_WR  = 3'b011;
    localparam logic [2:0] C_PRE = 3'b100;
    localparam logic [2:0] C_REF = 3'b101;

    localparam int D_RCD   = 14;
    localparam int D_RP    = 14;
    localparam int D_CL    = 14;
    localparam int D_CWL   = 12;
    localparam int D_BURST = 4;
    localparam int D_RFC   = 256;

    typedef struct {
        int            cyc;
        logic [4:0]    st;
        logic [AW-1:0] row;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bank_timing_fsm_if #(.ADDRWIDTH(AW)) bus();

    bank_timing_fsm #(.ADDRWIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [4:0]    m_st;
    int            m_rem;
    logic [AW-1:0] m_row;

    int         run_len [32];
    logic [4:0] prev_st = 5'b0;
    int         cur_len = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("BankFSM", 32'(bus.BankFSM), 32'(mon_e.st));
            chk("RowId", 32'(bus.RowId), 32'(mon_e.row));
            chk("cmd_err", 32'(bus.cmd_err), 32'(mon_e.err));
        end
        if (reset_n) begin
            if (bus.BankFSM == prev_st) begin
                cur_len++;
            end else begin
                run_len[prev_st] = cur_len;
                prev_st = bus.BankFSM;
                cur_len = 1;
            end
        end else begin
            prev_st = 5'b0;
            cur_len = 0;
        end
    end

    // Drive one cycle of inputs, check cmd_ready, advance the model, queue the expectation.
    task automatic step(input logic v, input logic [2:0] c, input logic [AW-1:0] r, input logic s);
        logic rdy;
        logic err_n;
        bus.cmd_valid = v;
        bus.cmd       = c;
        bus.row       = r;
        bus.stall     = s;
        #1;
        rdy = ((m_st == E_IDLE) || (m_st == E_BA)) && !s;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(rdy));
        err_n = 1'b0;
        if (!s) begin
            case (m_st)
                E_IDLE: if (v) begin
                    if (c == C_ACT) begin
                        m_st = E_ACTG; m_rem = D_RCD; m_row = r;
                    end else if (c == C_REF) begin
                        m_st = E_REF; m_rem = D_RFC;
                    end else if (c != C_PRE && c != C_NOP) begin
                        err_n = 1'b1;
                    end
                end
                E_BA: if (v) begin
                    if (c == C_RD) begin
                        m_st = E_RD; m_rem = D_CL;
                    end else if (c == C_WR) begin
                        m_st = E_WR; m_rem = D_CWL;
                    end else if (c == C_PRE) begin
                        m_st = E_PRE; m_rem = D_RP;
                    end else if (c != C_NOP) begin
                        err_n = 1'b1;
                    end
                end
                default: begin
                    if (m_rem > 1) begin
                        m_rem--;
                    end else begin
                        case (m_st)
                            E_RD: begin m_st = E_RB; m_rem = D_BURST; end
                            E_WR: begin m_st = E_WB; m_rem = D_BURST; end
                            E_PRE, E_REF: m_st = E_IDLE;
                            default: m_st = E_BA;
                        endcase
                    end
                end
            endcase
        end
        sb.push_back('{cyc + 1, m_st, m_row, err_n});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, C_NOP, '0, 1'b0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd       = C_NOP;
        bus.row       = '0;
        bus.stall     = 1'b0;
        m_st  = E_IDLE;
        m_rem = 0;
        m_row = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_state", 32'(bus.BankFSM), 32'(E_IDLE));
        chk("rst_row", 32'(bus.RowId), 32'h0);
        chk("rst_err", 32'(bus.cmd_err), 32'h0);

        step(1'b1, C_ACT, 17'h1ABCD, 1'b0);
        run(16);
        chk("len_activating", 32'(run_len[E_ACTG]), 32'd14);
        chk("row_open", 32'(bus.RowId), 32'h1ABCD);

        step(1'b1, C_RD, '0, 1'b0);
        run(20);
        chk("len_reading", 32'(run_len[E_RD]), 32'd14);
        chk("len_readburst", 32'(run_len[E_RB]), 32'd4);

        step(1'b1, C_WR, '0, 1'b0);
        run(18);
        chk("len_writing", 32'(run_len[E_WR]), 32'd12);
        chk("len_writeburst", 32'(run_len[E_WB]), 32'd4);

        step(1'b1, C_PRE, '0, 1'b0);
        run(16);
        chk("len_precharging", 32'(run_len[E_PRE]), 32'd14);
        chk("row_after_pre", 32'(bus.RowId), 32'h1ABCD);

        step(1'b1, C_REF, '0, 1'b0);
        run(258);
        chk("len_refreshing", 32'(run_len[E_REF]), 32'd256);

        // Illegal commands in IDLE, then a harmless PRE.
        step(1'b1, C_RD, '0, 1'b0);
        run(2);
        step(1'b1, 3'b111, '0, 1'b0);
        run(2);
        step(1'b1, C_PRE, '0, 1'b0);
        run(2);

        // Stall across the third ACTIVATING cycle.
        step(1'b1, C_ACT, 17'h0F00F, 1'b0);
        run(2);
        repeat (5) step(1'b0, C_NOP, '0, 1'b1);
        run(14);
        chk("len_act_stalled", 32'(run_len[E_ACTG]), 32'd19);
        step(1'b1, C_ACT, 17'h12345, 1'b1);
        run(2);
        chk("row_stall_act", 32'(bus.RowId), 32'h0F00F);
        step(1'b1, C_ACT, 17'h01111, 1'b0);
        run(2);
        chk("row_illegal_act", 32'(bus.RowId), 32'h0F00F);

        // Asynchronous reset in the middle of a read burst.
        step(1'b1, C_RD, '0, 1'b0);
        run(15);
        chk("pre_reset_state", 32'(bus.BankFSM), 32'(E_RB));
        sb.delete();
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.BankFSM), 32'(E_IDLE));
        chk("async_rst_row", 32'(bus.RowId), 32'h0);
        chk("async_rst_err", 32'(bus.cmd_err), 32'h0);
        m_st  = E_IDLE;
        m_rem = 0;
        m_row = '0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        step(1'b1, C_ACT, 17'h00ABC, 1'b0);
        run(16);
        chk("len_act_after_rst", 32'(run_len[E_ACTG]), 32'd14);
        chk("row_after_rst", 32'(bus.RowId), 32'h00ABC);

        run(2);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
